// File: rtl/sub_defs_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package sub_defs;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/fsubtractor1bit.sv
// One-bit full-subtractor cell: d = a - b - bin with borrow-out.
// Purely combinational; the serial subtractor instantiates exactly one.
module fsubtractor1bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a
// single full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor
  import sub_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             brw;
  logic             a_msb, b_msb;
  logic             cell_d, cell_bo;
  logic             last;
  logic [WIDTH-1:0] res_nxt;

  fsubtractor1bit u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .d    (cell_d),
    .bout (cell_bo)
  );

  assign last    = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
  // The new bit enters at the MSB so that bit k reaches position k after WIDTH shifts.
  assign res_nxt = {cell_d, res_sh};

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && start) begin
        a_sh   <= a;
        b_sh   <= b;
        brw    <= bin;
        a_msb  <= a[WIDTH-1];
        b_msb  <= b[WIDTH-1];
        res_sh <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        brw    <= cell_bo;
        res_sh <= res_nxt[WIDTH-1:1];
        cnt    <= cnt + CNT_W'(1);
        if (last) begin
          // The shift registers are consumed by now, so the operand signs come from dedicated flops.
          diff <= res_nxt;
          bout <= cell_bo;
          ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
          zero <= (res_nxt == '0);
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
